// File: rtl/pipeline_stage_memory_pkg.sv
// Shared definitions for the memory stage: access sizes, FSM states and the
// execute/memory pipeline result records.
package pipeline_stage_memory_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memory_state_t;

    typedef struct packed {
        logic      memRead;
        logic      memWrite;
        mem_size_t memSize;
        logic      memSigned;
        logic      regWriteEnabled;
    } control_signals_t;

    typedef struct packed {
        logic             bubbled;
        logic [31:0]      instruction;
        control_signals_t signals;
        logic [4:0]       regWriteId;
        logic [31:0]      aluResult;
        logic [31:0]      regDataStore;
        logic [31:0]      regDataWrite;
    } pipeline_result_execute_t;

    typedef struct packed {
        logic             bubbled;
        logic [31:0]      instruction;
        control_signals_t signals;
        logic [4:0]       regWriteId;
        logic [31:0]      regDataWrite;
    } pipeline_result_memory_t;

    // Empty slot handed to write-back: bubble flag set, everything else zero.
    function automatic pipeline_result_memory_t bubbleResult();
        pipeline_result_memory_t r;
        r = '0;
        r.bubbled = 1'b1;
        return r;
    endfunction

    // Carry the execute fields that write-back needs straight across.
    function automatic pipeline_result_memory_t passResult(input pipeline_result_execute_t e);
        pipeline_result_memory_t r;
        r.bubbled      = e.bubbled;
        r.instruction  = e.instruction;
        r.signals      = e.signals;
        r.regWriteId   = e.regWriteId;
        r.regDataWrite = e.regDataWrite;
        return r;
    endfunction

endpackage

// File: rtl/pipeline_stage_memory_if.sv
// Data-memory bus: pulse request from the stage, pulse ready from memory.
interface pipeline_stage_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  memRequest;
    logic                  memWriteEnable;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [3:0]            memByteEnable;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [DATA_WIDTH-1:0] memReadData;
    logic                  memReady;

    modport master (
        output memRequest, memWriteEnable, memAddress, memByteEnable, memWriteData,
        input  memReadData, memReady
    );

    modport slave (
        input  memRequest, memWriteEnable, memAddress, memByteEnable, memWriteData,
        output memReadData, memReady
    );
endinterface

// File: rtl/pipeline_stage_memory_lane_aligner.sv
// Little-endian lane handling: store byte-enable/data replication and
// load extraction with sign or zero extension.
module memory_lane_aligner
    import pipeline_stage_memory_pkg::*;
(
    input  mem_size_t   memSize,
    input  logic        memSigned,
    input  logic [1:0]  byteOffset,
    input  logic [31:0] storeData,
    input  logic [31:0] readData,
    output logic [3:0]  byteEnable,
    output logic [31:0] writeData,
    output logic [31:0] loadData
);
    logic [31:0] shiftedRead;

    assign shiftedRead = readData >> {byteOffset, 3'b000};

    // Select lanes and extension by access size; word accesses pass through.
    always_comb begin
        byteEnable = 4'b1111;
        writeData  = storeData;
        loadData   = readData;
        case (memSize)
            MEM_BYTE: begin
                byteEnable = 4'b0001 << byteOffset;
                writeData  = {4{storeData[7:0]}};
                loadData   = {{24{memSigned & shiftedRead[7]}}, shiftedRead[7:0]};
            end
            MEM_HALF: begin
                byteEnable = 4'b0011 << byteOffset;
                writeData  = {2{storeData[15:0]}};
                loadData   = {{16{memSigned & shiftedRead[15]}}, shiftedRead[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/pipeline_stage_memory.sv
// Memory stage: issues one data-memory access per load/store, stalls the
// front of the pipe until ready, and registers the result for write-back.
//
// state    | meaning
// MEM_IDLE | no access outstanding; memory ops issue their request here
// MEM_WAIT | request issued, stalling until memReady
module pipeline_stage_memory
    import pipeline_stage_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  pipeline_result_execute_t pipelineResultExecute,
    output logic                     stallOut,
    output logic                     addressError,
    output pipeline_result_memory_t  pipelineResultMemory,
    pipeline_stage_memory_if.master  memBus
);
    memory_state_t           state;
    memory_state_t           nextState;
    pipeline_result_memory_t nextResult;
    logic                    isMemOp;
    logic                    misaligned;
    logic [DATA_WIDTH-1:0]   loadData;
    logic [31:0]             effAddr;

    assign effAddr = pipelineResultExecute.aluResult;
    assign isMemOp = !pipelineResultExecute.bubbled &&
                     (pipelineResultExecute.signals.memRead || pipelineResultExecute.signals.memWrite);
    assign misaligned =
        ((pipelineResultExecute.signals.memSize == MEM_WORD) && (effAddr[1:0] != 2'b00)) ||
        ((pipelineResultExecute.signals.memSize == MEM_HALF) && effAddr[0]);

    // The input is frozen by the stall during WAIT, so lanes read it directly.
    memory_lane_aligner u_laneAligner (
        .memSize    (pipelineResultExecute.signals.memSize),
        .memSigned  (pipelineResultExecute.signals.memSigned),
        .byteOffset (effAddr[1:0]),
        .storeData  (pipelineResultExecute.regDataStore),
        .readData   (memBus.memReadData),
        .byteEnable (memBus.memByteEnable),
        .writeData  (memBus.memWriteData),
        .loadData   (loadData)
    );

    assign memBus.memAddress     = ADDR_WIDTH'({effAddr[31:2], 2'b00});
    assign memBus.memWriteEnable = pipelineResultExecute.signals.memWrite;

    // Next state, handshake outputs and next result; everything idles in reset.
    always_comb begin
        nextState         = state;
        stallOut          = 1'b0;
        addressError      = 1'b0;
        memBus.memRequest = 1'b0;
        nextResult        = bubbleResult();
        if (!reset) begin
            case (state)
                MEM_IDLE: begin
                    if (isMemOp) begin
                        if (misaligned) begin
                            addressError = 1'b1;
                        end else begin
                            memBus.memRequest = 1'b1;
                            stallOut          = 1'b1;
                            nextState         = MEM_WAIT;
                        end
                    end else begin
                        nextResult = passResult(pipelineResultExecute);
                    end
                end
                MEM_WAIT: begin
                    if (memBus.memReady) begin
                        nextResult = passResult(pipelineResultExecute);
                        if (pipelineResultExecute.signals.memWrite) begin
                            nextResult.signals.regWriteEnabled = 1'b0;
                        end else begin
                            nextResult.regDataWrite = loadData;
                        end
                        nextState = MEM_IDLE;
                    end else begin
                        stallOut = 1'b1;
                    end
                end
                default: nextState = MEM_IDLE;
            endcase
        end
    end

    // State and write-back result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= MEM_IDLE;
            pipelineResultMemory <= bubbleResult();
        end else begin
            state                <= nextState;
            pipelineResultMemory <= nextResult;
        end
    end
endmodule

// File: doc/pipeline_stage_memory.md
# pipeline_stage_memory

Memory stage of the five-stage pipeline. Sits between the execute stage and the write-back stage. Performs data-memory loads and stores over a pulse-request/pulse-ready handshake, and aligns and extends load data. Stalls upstream stages while an access is outstanding, then delivers a registered `pipeline_result_memory_t` to write-back.

## Interface
- `DATA_WIDTH`, 32, data-memory word width; only 32 is supported.
- `ADDR_WIDTH`, 32, byte address width.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pipelineResultExecute`  in  pipeline_result_execute_t  from execute. Uses `bubbled`, `instruction`, `signals` (`memRead`, `memWrite`, `memSize`, `memSigned`, `regWriteEnabled`), `regWriteId`, `aluResult` (effective address), `regDataStore`, `regDataWrite`.
- `stallOut`  out  1  freeze fetch/decode/execute this cycle.
- `memRequest`  out  1  single-cycle access request.
- `memWriteEnable`  out  1  1 = store, 0 = load; valid with `memRequest`.
- `memAddress`  out  ADDR_WIDTH  word-aligned address `{aluResult[31:2],2'b00}`.
- `memByteEnable`  out  4  store lane mask.
- `memWriteData`  out  DATA_WIDTH  lane-replicated store data.
- `memReadData`  in  DATA_WIDTH  valid when `memReady`=1.
- `memReady`  in  1  single-cycle completion pulse, at least 1 cycle after `memRequest`.
- `addressError`  out  1  one-cycle pulse on a misaligned access.
- `pipelineResultMemory`  out  pipeline_result_memory_t  registered result to write-back.

## Operation
- A memory op is a non-bubbled input with `memRead` or `memWrite` set.
- FSM states are IDLE and WAIT.
- IDLE, aligned memory op:
  - Assert `memRequest` combinationally, with address, byte enables and data.
  - Assert `stallOut`; the output register loads a bubble.
  - Next state WAIT.
- IDLE, non-memory op or bubble: the output register loads the input fields the same edge. `regDataWrite` passes through.
- WAIT:
  - `stallOut`=1 and `memRequest`=0 until `memReady`.
  - On `memReady`: `stallOut`=0 and the output register loads the result.
  - Loads replace `regDataWrite` with the extracted value. Stores force `regWriteEnabled`=0.
  - Next state IDLE.
- Misaligned access:
  - Word with `addr[1:0]`≠0, or half with `addr[0]`=1.
  - No request is issued.
  - `addressError` pulses for the cycle.
  - The output loads a bubble; no stall.
- Store lanes (little-endian):
  - Byte: enables `4'b0001<<addr[1:0]`, data `{4{d[7:0]}}`.
  - Half: enables `4'b0011<<addr[1:0]`, data `{2{d[15:0]}}`.
  - Word: enables `4'b1111`.
- Load extract:
  - Byte: `memReadData>>(8*addr[1:0])`.
  - Half: `memReadData>>(8*addr[1:0])`.
  - Both then sign-extend if `memSigned`, else zero-extend.
  - Word: passes through unchanged.
- `memReady` in IDLE is ignored.
- `memReadData` for stores is ignored.

## Timing
- Non-memory ops have 1-cycle latency.
- A memory op with ready N cycles after the request:
  - `stallOut` high N cycles, counting the request cycle but not the ready cycle.
  - The result appears on the edge ending the ready cycle.
- Minimum memory-op latency is 2 cycles (N=1).
- Reset values:
  - `pipelineResultMemory.bubbled`=1; all other result fields 0.
  - `stallOut`=0, `memRequest`=0, `addressError`=0.
  - FSM in IDLE.
- Reset in WAIT returns to IDLE. The pending access is abandoned; its later `memReady` is ignored and produces no result.
- The input is held constant by the stall during WAIT, so the lane and extract logic may read it directly.

## Structure
- In the shared definitions package:
  - `mem_size_t` enum {MEM_BYTE, MEM_HALF, MEM_WORD}.
  - `memory_state_t` enum {MEM_IDLE, MEM_WAIT}.
  - The `memSize`/`memSigned` fields of the control-signal struct.
- One combinational sub-module, `memory_lane_aligner`: store enable/data formation and load extraction/extension. It is unit-testable alone.

## Test plan
- Hold reset 2 cycles with an arbitrary input → `bubbled`=1, `stallOut`=0, `memRequest`=0, `addressError`=0.
- lw at 0x100; `memReady` 3 cycles after the request with data 0xDEADBEEF → one `memRequest` pulse at address 0x100, `stallOut` high 3 cycles, then `regDataWrite`=0xDEADBEEF with `regWriteEnabled`=1.
- lb signed at 0x103 with read data 0x80123456 → 0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x102 → 0x00008012.
- sh at 0x102 with store data 0x0000ABCD → `memByteEnable`=4'b1100, `memWriteData`=0xABCDABCD, `memWriteEnable`=1, result `regWriteEnabled`=0.
- lw at 0x102 → no `memRequest`, `addressError` pulse of 1 cycle, output bubbled, `stallOut`=0.
- lw issued, reset asserted in WAIT, `memReady` arrives 2 cycles later → state stays IDLE, output stays bubbled, no spurious `stallOut`.
